// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter that produces the per-user drive enables for N
//   BusUsers sharing one 3-state data bus. At most one enable is high at any
//   time. After every release the bus is left undriven for GAP cycles, so a
//   BusUser whose output enable is registered has let go of the bus before
//   the next owner starts driving.
//
// Ports
//   clk       rising-edge clock shared with all BusUsers
//   rst_n     asynchronous active-low reset
//   req       [N-1:0] level-sensitive request lines, one per user
//   en        [N-1:0] registered one-hot (or zero) grant to BusUser en
//   owner     index of the current grantee (valid while busy=1; keeps its
//             last value after a release)
//   busy      high whenever any en bit is high
//   dbg_state current FSM state (IDLE=0, GRANT=1, TURN=2) for observation
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int GAP      = 1,
  localparam int PW      = $clog2(N),
  localparam int HW      = $clog2(MAX_HOLD + 1),
  localparam int GW      = $clog2(GAP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  en,
  output logic [PW-1:0] owner,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [HW-1:0] hold;
  logic [GW-1:0] gap;

  logic [PW-1:0] win;
  logic [N-1:0]  win_oh;
  logic [N-1:0]  own_oh;
  logic          others_req;
  logic          hold_full;
  logic          gap_done;
  logic [PW-1:0] ptr_next;

  // Round-robin search: walk from ptr+N-1 down to ptr so that the last
  // match written is the first set request in ptr, ptr+1, ... order.
  always_comb begin
    int idx;
    win = '0;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) win = PW'(idx);
    end
  end

  assign win_oh     = {{(N-1){1'b0}}, 1'b1} << win;
  assign own_oh     = {{(N-1){1'b0}}, 1'b1} << owner;
  assign others_req = |(req & ~own_oh);
  assign hold_full  = (hold == HW'(MAX_HOLD));
  assign gap_done   = (gap == GW'(GAP));
  // Released owner drops to lowest priority; wraps N-1 -> 0.
  assign ptr_next   = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);

  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      en    <= '0;
      owner <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
      hold  <= '0;
      gap   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            en    <= win_oh;
            owner <= win;
            busy  <= 1'b1;
            hold  <= HW'(1);
            state <= GRANT;
          end
        end

        GRANT: begin
          // Owner dropping its request wins over the hold limit; a sole
          // requester is never preempted because others_req stays low.
          if (!req[owner] || (hold_full && others_req)) begin
            en    <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            gap   <= GW'(1);
            state <= TURN;
          end else if (!hold_full) begin
            hold <= hold + HW'(1);
          end
        end

        TURN: begin
          // Requests are not looked at until the full gap has elapsed.
          if (!gap_done) begin
            gap <= gap + GW'(1);
          end else if (|req) begin
            en    <= win_oh;
            owner <= win;
            busy  <= 1'b1;
            hold  <= HW'(1);
            state <= GRANT;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          en    <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Drives bus_arbiter (N=4, MAX_HOLD=8, GAP=1) with directed scenarios and
//   a long randomized request stream. A bus-level model tracks who owns the
//   bus, how long they have held it, and how many quiet cycles have passed
//   since the last release; a compare process checks en/owner/busy against
//   it every cycle. Directed scenarios also pin literal expectations.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int GAP      = 1;
  localparam int PW       = $clog2(N);

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  en;
  logic [PW-1:0] owner;
  logic          busy;
  logic [1:0]    dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .owner     (owner),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- bus-level reference model ----------------
  // cur_own  : user currently driving the bus, -1 when nobody is
  // run_len  : cycles the current owner has held the bus so far
  // quiet    : undriven cycles since the last release
  // next_pri : user searched first at the next grant
  int cur_own  = -1;
  int last_own = 0;
  int run_len  = 0;
  int quiet    = GAP;
  int next_pri = 0;

  function automatic logic [N-1:0] model_en();
    logic [N-1:0] v;
    v = '0;
    if (cur_own >= 0) v[cur_own] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_own  = -1;
      last_own = 0;
      run_len  = 0;
      quiet    = GAP;
      next_pri = 0;
    end else if (cur_own >= 0) begin
      logic [N-1:0] others;
      others = req;
      others[cur_own] = 1'b0;
      if (!req[cur_own] || (run_len >= MAX_HOLD && others != '0)) begin
        next_pri = (cur_own + 1) % N;
        cur_own  = -1;
        quiet    = 1;
      end else begin
        run_len = run_len + 1;
      end
    end else if (quiet < GAP) begin
      quiet = quiet + 1;
    end else if (req != '0) begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (next_pri + k) % N;
        if (!found && req[j]) begin
          found   = 1'b1;
          cur_own = j;
        end
      end
      last_own = cur_own;
      run_len  = 1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, plus a bus monitor: never two
  // drivers, never an unknown enable, busy tracks |en.
  always @(posedge clk) begin
    #2;
    chk("model_en",    32'(en), 32'(model_en()));
    chk("model_busy",  32'(busy), 32'(cur_own >= 0));
    chk("model_owner", 32'(owner), 32'(last_own));
    chk("bus_drivers", 32'(($countones(en) <= 1) && !$isunknown(en)), 32'd1);
    chk("busy_vs_en",  32'(busy), 32'(|en));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    rst_n = 1'b0;
    req   = r;
    #1;
    chk("rst_en",   32'(en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    tick();
    chk("rst_hold_en",    32'(en), 32'h0);
    chk("rst_hold_owner", 32'(owner), 32'h0);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    req   = '0;
    #1;

    // Reset with everyone requesting; first edge after release grants 0.
    do_reset(4'b1111);
    tick();
    chk("first_grant_en",    32'(en), 32'b0001);
    chk("first_grant_owner", 32'(owner), 32'd0);

    // Single user: granted in one edge, released when it drops req.
    do_reset(4'b0100);
    tick();
    chk("single_en", 32'(en), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_hold", 32'(en), 32'b0100);
    end
    req = 4'b0000;
    tick();
    chk("single_release", 32'(en), 32'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_quiet", 32'(en), 32'b0000);
    end

    // Handover with exactly one quiet cycle.
    do_reset(4'b0110);
    tick();
    chk("handover_first", 32'(en), 32'b0010);
    tick();
    chk("handover_hold", 32'(en), 32'b0010);
    req = 4'b0100;
    tick();
    chk("handover_gap", 32'(en), 32'b0000);
    tick();
    chk("handover_next", 32'(en), 32'b0100);
    chk("handover_owner", 32'(owner), 32'd2);

    // Preemption: 8 cycles each, one gap cycle between.
    do_reset(4'b0011);
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      chk("preempt_u0", 32'(en), 32'b0001);
    end
    tick();
    chk("preempt_gap0", 32'(en), 32'b0000);
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      chk("preempt_u1", 32'(en), 32'b0010);
    end
    tick();
    chk("preempt_gap1", 32'(en), 32'b0000);
    tick();
    chk("preempt_back_u0", 32'(en), 32'b0001);

    // Sole requester is never preempted.
    do_reset(4'b0100);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sole_hold", 32'(en), 32'b0100);
    end

    // Round-robin wrap: owner 3 preempted, next grant goes to 0.
    do_reset(4'b1000);
    tick();
    chk("wrap_u3", 32'(en), 32'b1000);
    req = 4'b1001;
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick();
      chk("wrap_u3_hold", 32'(en), 32'b1000);
    end
    tick();
    chk("wrap_gap", 32'(en), 32'b0000);
    tick();
    chk("wrap_u0", 32'(en), 32'b0001);
    chk("wrap_owner", 32'(owner), 32'd0);

    // Asynchronous reset in the middle of a grant.
    do_reset(4'b1000);
    tick();
    tick();
    chk("async_pre_en", 32'(en), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("async_en",   32'(en), 32'b0000);
    chk("async_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("async_regrant", 32'(en), 32'b1000);

    // Randomized stream: requests toggle occasionally so holds reach the
    // limit, with rare asynchronous reset pulses between edges.
    do_reset(4'b0000);
    for (int c = 0; c < 4000; c++) begin
      logic [N-1:0] r;
      r = req;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
      end
      req = r;
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      tick();
    end

    req = '0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
